// File: rtl/spi_pkg.sv
// Shared types for the synchronous SPI slave: FSM states and SPI mode encodings.
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        XFER = 2'd2
    } state_t;

    // Modes encoded as {cpol, cpha}
    localparam logic [1:0] MODE0 = 2'b00;
    localparam logic [1:0] MODE1 = 2'b01;
    localparam logic [1:0] MODE2 = 2'b10;
    localparam logic [1:0] MODE3 = 2'b11;

endpackage

// File: rtl/spi_slave_sync_if.sv
// Pin, configuration and tx/rx handshake bundle of the synchronous SPI slave.
interface spi_slave_sync_if #(
    parameter int DW = 8
);
    logic          ss;
    logic          sck;
    logic          sdin;
    logic          sdout;
    logic          sdout_oe;
    logic          cpol;
    logic          cpha;
    logic          mlb;
    logic [DW-1:0] tdata;
    logic          tvalid;
    logic          tready;
    logic [DW-1:0] rdata;
    logic          rvalid;
    logic          done;
    logic          underrun;
    logic          abort;

    modport slave (
        input  ss, sck, sdin, cpol, cpha, mlb, tdata, tvalid,
        output sdout, sdout_oe, tready, rdata, rvalid, done, underrun, abort
    );

    modport master (
        output ss, sck, sdin, cpol, cpha, mlb, tdata, tvalid,
        input  sdout, sdout_oe, tready, rdata, rvalid, done, underrun, abort
    );
endinterface

// File: rtl/spi_sync_edge.sv
// N-stage synchroniser for an asynchronous pin with registered rise/fall detection.
module spi_sync_edge #(
    parameter int   N    = 2,
    parameter logic INIT = 1'b0
) (
    input  logic clk,
    input  logic rstb,
    input  logic d,
    output logic rise,
    output logic fall
);

    logic [N-1:0] sync_q;
    logic         prev_q;

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            sync_q <= {N{INIT}};
            prev_q <= INIT;
        end else begin
            sync_q <= {sync_q[N-2:0], d};
            prev_q <= sync_q[N-1];
        end
    end

    assign rise = sync_q[N-1] & ~prev_q;
    assign fall = ~sync_q[N-1] & prev_q;

endmodule

// File: rtl/spi_slave_sync.sv
// System-clocked SPI slave: runtime mode/bit order, tx holding register, multi-word frames,
// underrun and abort reporting.
module spi_slave_sync
    import spi_pkg::*;
#(
    parameter int  DW          = 8,
    parameter int  SYNC_STAGES = 2,
    localparam int CW          = $clog2(DW + 1)
) (
    input  logic              clk,
    input  logic              rstb,
    spi_slave_sync_if.slave   bus
);

    state_t        state, state_nxt;
    logic          ss_rise, ss_fall, sck_rise, sck_fall, sdin_s;
    logic [SYNC_STAGES-1:0] sdin_sync;
    logic          cpol_l, cpha_l, mlb_l;
    logic          lead, trail, sample_x, shift_x, word_end, commit;
    logic          oe, load_en;
    logic          hold_full, fresh, pend, pend_full;
    logic [DW-1:0] hold_q, txsh, rxsh, word_sel, rdata_q;
    logic [CW-1:0] bitcnt;
    logic          sdout_q, rvalid_q, done_q, underrun_q, abort_q;

    function automatic logic first_bit(input logic [DW-1:0] w, input logic msb);
        return msb ? w[DW-1] : w[0];
    endfunction

    function automatic logic [DW-1:0] shift_out(input logic [DW-1:0] w, input logic msb);
        return msb ? {w[DW-2:0], 1'b0} : {1'b0, w[DW-1:1]};
    endfunction

    spi_sync_edge #(.N(SYNC_STAGES), .INIT(1'b1)) u_ss_sync (
        .clk(clk), .rstb(rstb), .d(bus.ss), .rise(ss_rise), .fall(ss_fall)
    );

    spi_sync_edge #(.N(SYNC_STAGES), .INIT(1'b0)) u_sck_sync (
        .clk(clk), .rstb(rstb), .d(bus.sck), .rise(sck_rise), .fall(sck_fall)
    );

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) sdin_sync <= '0;
        else       sdin_sync <= {sdin_sync[SYNC_STAGES-2:0], bus.sdin};
    end
    assign sdin_s = sdin_sync[SYNC_STAGES-1];

    assign lead     = cpol_l ? sck_fall : sck_rise;
    assign trail    = cpol_l ? sck_rise : sck_fall;
    assign sample_x = (state == XFER) && (cpha_l ? trail : lead);
    assign shift_x  = (state == XFER) && !ss_rise && (cpha_l ? lead : trail);
    assign word_end = (bitcnt == CW'(DW));
    assign commit   = sample_x && pend;
    assign word_sel = hold_full ? hold_q : '0;

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (ss_fall) state_nxt = LOAD;
            LOAD:    state_nxt = ss_rise ? IDLE : XFER;
            XFER:    if (ss_rise) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        oe      = 1'b0;
        load_en = 1'b0;
        unique case (state)
            LOAD: begin
                oe      = 1'b1;
                load_en = 1'b1;
            end
            XFER:    oe = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            cpol_l <= 1'b0; cpha_l <= 1'b0; mlb_l <= 1'b1;
            hold_full <= 1'b0; fresh <= 1'b0; pend <= 1'b0; pend_full <= 1'b0;
            bitcnt <= '0; sdout_q <= 1'b0; rdata_q <= '0;
            rvalid_q <= 1'b0; done_q <= 1'b0; underrun_q <= 1'b0; abort_q <= 1'b0;
        end else begin
            rvalid_q <= word_end;
            done_q   <= word_end;
            abort_q  <= 1'b0;
            if (word_end) rdata_q <= rxsh;
            if (state == IDLE && ss_fall) begin
                cpol_l     <= bus.cpol;
                cpha_l     <= bus.cpha;
                mlb_l      <= bus.mlb;
                underrun_q <= 1'b0;
            end

            if (bus.tvalid && !hold_full)                               hold_full <= 1'b1;
            else if ((load_en && hold_full) || (commit && pend_full))   hold_full <= 1'b0;
            if ((load_en && !hold_full) || (commit && !pend_full))      underrun_q <= 1'b1;

            // A final sample coinciding with ss rise still completes the word
            if (word_end)
                bitcnt <= '0;
            else if (ss_rise)
                bitcnt <= (sample_x && bitcnt == CW'(DW - 1)) ? CW'(DW) : '0;
            else if (state == IDLE)
                bitcnt <= '0;
            else if (sample_x)
                bitcnt <= bitcnt + CW'(1);

            if (ss_rise && bitcnt != '0 && !word_end && !(sample_x && bitcnt == CW'(DW - 1)))
                abort_q <= 1'b1;

            // Inter-word reloads only peek at holding; it is consumed at the following
            // sample edge, so a trailing sck edge ending a mode 0/2 frame never eats a word.
            if (state == IDLE) begin
                sdout_q <= 1'b0;
                pend    <= 1'b0;
                fresh   <= 1'b0;
            end else if (load_en) begin
                pend  <= 1'b0;
                fresh <= cpha_l;
                if (!cpha_l) sdout_q <= first_bit(word_sel, mlb_l);
            end else if (shift_x) begin
                if (bitcnt == '0 && !fresh) begin
                    sdout_q   <= first_bit(word_sel, mlb_l);
                    pend      <= 1'b1;
                    pend_full <= hold_full;
                end else begin
                    sdout_q <= first_bit(txsh, mlb_l);
                    fresh   <= 1'b0;
                end
            end
            if (commit) pend <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (bus.tvalid && !hold_full) hold_q <= bus.tdata;
        if (load_en)
            txsh <= cpha_l ? word_sel : shift_out(word_sel, mlb_l);
        else if (shift_x)
            txsh <= (bitcnt == '0 && !fresh) ? shift_out(word_sel, mlb_l) : shift_out(txsh, mlb_l);
        if (sample_x)
            rxsh <= mlb_l ? {rxsh[DW-2:0], sdin_s} : {sdin_s, rxsh[DW-1:1]};
    end

    assign bus.sdout    = sdout_q;
    assign bus.sdout_oe = oe;
    assign bus.tready   = ~hold_full;
    assign bus.rdata    = rdata_q;
    assign bus.rvalid   = rvalid_q;
    assign bus.done     = done_q;
    assign bus.underrun = underrun_q;
    assign bus.abort    = abort_q;

endmodule
